// File: rtl/monocycle_pkg.sv
// Shared opcode/funct constants, control-word types and the instruction decoder.
// The decoder honours MONOCYCLE_EXT_BRANCH_EN (adds bne/blt/bge when defined).
package monocycle_pkg;

   localparam int XLEN_DEFAULT = 64;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_SD  = 3'b011;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   typedef enum logic [1:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR
   } alu_op_t;

   typedef enum logic [2:0] {
      BR_NONE,
      BR_EQ,
      BR_NE,
      BR_LT,
      BR_GE
   } br_t;

   typedef struct packed {
      logic    reg_we;
      logic    mem_we;
      logic    mem_to_reg;
      logic    alu_src_imm;
      logic    use_imm_s;
      br_t     br;
      alu_op_t alu_op;
   } ctrl_t;

   // Anything not matched below falls through as a NOP: no writes, PC+4.
   function automatic ctrl_t decode(input logic [6:0] opcode,
                                    input logic [2:0] funct3,
                                    input logic [6:0] funct7);
      ctrl_t c;
      c        = '0;
      c.br     = BR_NONE;
      c.alu_op = ALU_ADD;
      case (opcode)
         OP_R: begin
            if (funct3 == F3_ADD && funct7 == F7_BASE) begin
               c.reg_we = 1'b1;
               c.alu_op = ALU_ADD;
            end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
               c.reg_we = 1'b1;
               c.alu_op = ALU_SUB;
            end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
               c.reg_we = 1'b1;
               c.alu_op = ALU_AND;
            end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
               c.reg_we = 1'b1;
               c.alu_op = ALU_OR;
            end
         end
         OP_IMM: begin
            if (funct3 == F3_ADD) begin
               c.reg_we      = 1'b1;
               c.alu_src_imm = 1'b1;
            end
         end
         OP_LOAD: begin
            if (funct3 == F3_LD) begin
               c.reg_we      = 1'b1;
               c.mem_to_reg  = 1'b1;
               c.alu_src_imm = 1'b1;
            end
         end
         OP_STORE: begin
            if (funct3 == F3_SD) begin
               c.mem_we      = 1'b1;
               c.alu_src_imm = 1'b1;
               c.use_imm_s   = 1'b1;
            end
         end
         OP_BRANCH: begin
            c.alu_op = ALU_SUB;
            case (funct3)
               F3_BEQ:  c.br = BR_EQ;
`ifdef MONOCYCLE_EXT_BRANCH_EN
               F3_BNE:  c.br = BR_NE;
               F3_BLT:  c.br = BR_LT;
               F3_BGE:  c.br = BR_GE;
`endif
               default: c.br = BR_NONE;
            endcase
         end
         default: c = c;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/monocycle_alu.sv
// 64-bit two's-complement ALU (add/sub/and/or) with a zero flag.
module monocycle_alu
   import monocycle_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  alu_op_t         op,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   always_comb begin
      result = '0;
      unique case (op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/monocycle_core.sv
// Single-cycle RV64I-subset CPU: PC, instruction memory, regfile, ALU, data memory.
// Define MONOCYCLE_EXT_BRANCH_EN to add bne/blt/bge; otherwise they execute as NOPs.
module monocycle_core
   import monocycle_pkg::*;
#(
   parameter int XLEN       = XLEN_DEFAULT,
   parameter int IMEM_WORDS = 64,
   parameter int DMEM_BYTES = 256
) (
   input logic CLK,
   input logic RST
);

   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_BYTES);
   localparam int NB  = XLEN / 8;

   genvar gi;

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next;
   logic [31:0]     instr;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      rd;
   ctrl_t           ctrl;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] wb_data;
   logic            branch_taken;
   logic [DAW-1:0]  mem_addr;

   // Named blocks give the state elements their fixed hierarchical paths.
   if (1) begin : pc_reg
      logic [XLEN-1:0] OUT;
      always_ff @(posedge CLK) begin
         if (RST) OUT <= '0;
         else     OUT <= pc_next;
      end
      assign pc = OUT;
   end

   if (1) begin : imem
      logic [31:0] memory [IMEM_WORDS];
      // Contents arrive through the hierarchy; this hold keeps them across edges.
      always_ff @(posedge CLK) begin
         for (int i = 0; i < IMEM_WORDS; i++) memory[i] <= memory[i];
      end
      assign instr = memory[pc[IAW+1:2]];
   end

   assign rs1  = instr[19:15];
   assign rs2  = instr[24:20];
   assign rd   = instr[11:7];
   assign ctrl = decode(instr[6:0], instr[14:12], instr[31:25]);

   assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                   instr[11:8], 1'b0};

   if (1) begin : regfile
      logic [XLEN-1:0] registers [32];
      always_ff @(posedge CLK) begin
         if (RST) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
         end else if (ctrl.reg_we && rd != 5'd0) begin
            registers[rd] <= wb_data;
         end
      end
      assign rs1_val = (rs1 == 5'd0) ? '0 : registers[rs1];
      assign rs2_val = (rs2 == 5'd0) ? '0 : registers[rs2];
   end

   assign alu_b = ctrl.alu_src_imm ? (ctrl.use_imm_s ? imm_s : imm_i) : rs2_val;

   monocycle_alu #(.XLEN(XLEN)) u_alu (
      .a      (rs1_val),
      .b      (alu_b),
      .op     (ctrl.alu_op),
      .result (alu_result),
      .zero   (alu_zero)
   );

   assign mem_addr = alu_result[DAW-1:0];

   if (1) begin : dmem
      logic [7:0]     memory [DMEM_BYTES];
      logic [DAW-1:0] byte_addr [NB];

      // Byte lanes wrap independently, so misaligned doublewords straddle the top.
      for (gi = 0; gi < NB; gi++) begin : g_byte
         assign byte_addr[gi]       = mem_addr + DAW'(gi);
         assign load_data[8*gi +: 8] = memory[byte_addr[gi]];
      end

      always_ff @(posedge CLK) begin
         if (!RST && ctrl.mem_we) begin
            for (int i = 0; i < NB; i++) memory[byte_addr[i]] <= rs2_val[8*i +: 8];
         end
      end
   end

   assign wb_data = ctrl.mem_to_reg ? load_data : alu_result;

   always_comb begin
      branch_taken = 1'b0;
      case (ctrl.br)
         BR_EQ:   branch_taken = alu_zero;
         BR_NE:   branch_taken = !alu_zero;
         BR_LT:   branch_taken = $signed(rs1_val) <  $signed(rs2_val);
         BR_GE:   branch_taken = $signed(rs1_val) >= $signed(rs2_val);
         default: branch_taken = 1'b0;
      endcase
   end

   assign pc_next = branch_taken ? (pc + imm_b) : (pc + XLEN'(4));

endmodule

// File: tb/tb_monocycle_core.sv
// Scoreboard bench for monocycle_core: an instruction-level model predicts each
// retired instruction; a negedge monitor pops and compares against DUT state.
`timescale 1ns/1ps
module tb_monocycle_core;

   localparam int XLEN       = 64;
   localparam int IMEM_WORDS = 64;
   localparam int DMEM_BYTES = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   monocycle_core #(
      .XLEN       (XLEN),
      .IMEM_WORDS (IMEM_WORDS),
      .DMEM_BYTES (DMEM_BYTES)
   ) dut (
      .CLK (clk),
      .RST (rst)
   );

   typedef struct {
      int          kind;   // 0 = pc, 1 = register, 2 = doubleword in dmem
      int          idx;
      logic [63:0] val;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;

   logic [31:0] m_imem [IMEM_WORDS];
   logic [63:0] m_regs [32];
   logic [7:0]  m_dmem [DMEM_BYTES];
   logic [63:0] m_pc;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endfunction

   // ---------------- encoders ----------------
   function automatic logic [31:0] enc_r(int f7, int r2, int r1, int f3, int rd);
      return {7'(f7), 5'(r2), 5'(r1), 3'(f3), 5'(rd), 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(int imm, int r1, int f3, int rd, int op);
      logic [11:0] im;
      im = 12'(imm);
      return {im, 5'(r1), 3'(f3), 5'(rd), 7'(op)};
   endfunction
   function automatic logic [31:0] enc_s(int imm, int r2, int r1, int f3);
      logic [11:0] im;
      im = 12'(imm);
      return {im[11:5], 5'(r2), 5'(r1), 3'(f3), im[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(int off, int r2, int r1, int f3);
      logic [12:0] im;
      im = 13'(off);
      return {im[12], im[10:5], 5'(r2), 5'(r1), 3'(f3), im[4:1], im[11], 7'h63};
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [63:0] m_read_dword(int addr);
      logic [63:0] v;
      for (int k = 0; k < 8; k++) v[8*k +: 8] = m_dmem[(addr + k) % DMEM_BYTES];
      return v;
   endfunction

   task automatic model_step();
      logic [31:0] ins;
      logic [63:0] a, b, ii, is, ib, wdat, npc;
      logic [4:0]  rd, r1, r2;
      logic [2:0]  f3;
      logic [6:0]  f7, op;
      bit          we, st, take;
      int          addr;
      ins  = m_imem[int'((m_pc >> 2) % IMEM_WORDS)];
      op   = ins[6:0];   rd = ins[11:7];   f3 = ins[14:12];
      r1   = ins[19:15]; r2 = ins[24:20];  f7 = ins[31:25];
      a    = m_regs[r1];
      b    = m_regs[r2];
      ii   = 64'($signed(ins[31:20]));
      is   = 64'($signed({ins[31:25], ins[11:7]}));
      ib   = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      we   = 0; st = 0; take = 0; wdat = 0; addr = 0;
      case (op)
         7'h33: begin
            if (f3 == 0 && f7 == 7'h00)      begin we = 1; wdat = a + b; end
            else if (f3 == 0 && f7 == 7'h20) begin we = 1; wdat = a - b; end
            else if (f3 == 7 && f7 == 7'h00) begin we = 1; wdat = a & b; end
            else if (f3 == 6 && f7 == 7'h00) begin we = 1; wdat = a | b; end
         end
         7'h13: if (f3 == 0) begin we = 1; wdat = a + ii; end
         7'h03: if (f3 == 3) begin
            addr = int'((a + ii) % 64'(DMEM_BYTES));
            we   = 1;
            wdat = m_read_dword(addr);
         end
         7'h23: if (f3 == 3) begin
            addr = int'((a + is) % 64'(DMEM_BYTES));
            st   = 1;
         end
         7'h63: begin
            if (f3 == 0) take = (a == b);
`ifdef MONOCYCLE_EXT_BRANCH_EN
            if (f3 == 1) take = (a != b);
            if (f3 == 4) take = ($signed(a) <  $signed(b));
            if (f3 == 5) take = ($signed(a) >= $signed(b));
`endif
         end
         default: ;
      endcase
      if (st) for (int k = 0; k < 8; k++) m_dmem[(addr + k) % DMEM_BYTES] = b[8*k +: 8];
      if (we && rd != 0) m_regs[rd] = wdat;
      npc  = take ? m_pc + ib : m_pc + 64'd4;
      m_pc = npc;
      exp_q.push_back('{kind: 1, idx: int'(rd), val: m_regs[rd]});
      if (st) exp_q.push_back('{kind: 2, idx: addr, val: b});
      exp_q.push_back('{kind: 0, idx: 0, val: m_pc});
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] v;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.kind)
            0: begin
               chk($sformatf("pc@cyc%0d", cyc), dut.pc_reg.OUT, e.val);
               $display("cyc %0d retired, pc=%h", cyc, dut.pc_reg.OUT);
               cyc++;
            end
            1: chk($sformatf("x%0d@cyc%0d", e.idx, cyc), dut.regfile.registers[e.idx], e.val);
            default: begin
               for (int k = 0; k < 8; k++) v[8*k +: 8] = dut.dmem.memory[(e.idx + k) % DMEM_BYTES];
               chk($sformatf("dmem[%0d]@cyc%0d", e.idx, cyc), v, e.val);
            end
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic load_prog(input logic [31:0] prog[$]);
      for (int i = 0; i < IMEM_WORDS; i++) begin
         m_imem[i]          = (i < prog.size()) ? prog[i] : 32'h0000007F;
         dut.imem.memory[i] = m_imem[i];
      end
   endtask

   task automatic set_dmem_random();
      for (int i = 0; i < DMEM_BYTES; i++) begin
         m_dmem[i]          = 8'($urandom);
         dut.dmem.memory[i] = m_dmem[i];
      end
   endtask

   task automatic check_reset_state(string tag);
      int nz, nd;
      nz = 0; nd = 0;
      chk({tag, "_pc"}, dut.pc_reg.OUT, 64'd0);
      for (int i = 0; i < 32; i++) if (dut.regfile.registers[i] !== 64'd0) nz++;
      chk({tag, "_regs_nonzero"}, 64'(nz), 64'd0);
      for (int i = 0; i < DMEM_BYTES; i++) if (dut.dmem.memory[i] !== m_dmem[i]) nd++;
      chk({tag, "_dmem_changed"}, 64'(nd), 64'd0);
   endtask

   // Called between negedge and posedge; returns at negedge+1.
   task automatic do_reset(int n, string tag);
      rst  = 1'b1;
      m_pc = 64'd0;
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      repeat (n) @(posedge clk);
      @(negedge clk); #1;
      check_reset_state(tag);
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) begin
         rst = 1'b0;
         model_step();
         @(posedge clk);
         @(negedge clk); #1;
      end
   endtask

   function automatic logic [31:0] rand_instr();
      int k, rd, r1, r2, imm, boff;
      logic [31:0] w;
      k    = int'($urandom_range(0, 11));
      rd   = int'($urandom_range(0, 7));
      r1   = int'($urandom_range(0, 7));
      r2   = int'($urandom_range(0, 7));
      imm  = int'($urandom_range(0, 4095)) - 2048;
      boff = (int'($urandom_range(0, 6)) - 2) * 4;
      case (k)
         0:  w = enc_r(0,    r2, r1, 0, rd);
         1:  w = enc_r(32,   r2, r1, 0, rd);
         2:  w = enc_r(0,    r2, r1, 7, rd);
         3:  w = enc_r(0,    r2, r1, 6, rd);
         4:  w = enc_i(imm,  r1, 0, rd, 7'h13);
         5:  w = enc_i(imm,  r1, 3, rd, 7'h03);
         6:  w = enc_s(imm,  r2, r1, 3);
         7:  w = enc_b(boff, r2, r1, 0);
         8:  w = enc_b(boff, r2, r1, ($urandom_range(0, 2) == 0) ? 1 : int'($urandom_range(4, 5)));
         9:  w = enc_b(boff, r2, r1, ($urandom_range(0, 1) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(6, 7)));
         10: w = {25'($urandom), 7'h7F};
         default: w = ($urandom_range(0, 1) == 0) ? enc_r(1, r2, r1, 0, rd) : enc_i(imm, r1, 1, rd, 7'h13);
      endcase
      return w;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] prog[$];
      logic [63:0] v;

      // ---- directed program ----
      @(negedge clk); #1;
      set_dmem_random();
      for (int i = 0; i < 16; i++) begin
         m_dmem[i] = (i == 0) ? 8'h0A : (i == 8) ? 8'h14 : 8'h00;
         dut.dmem.memory[i] = m_dmem[i];
      end
      prog = {};
      prog.push_back(enc_i(0, 0, 3, 1, 7'h03));      //  0 ld  x1,0(x0)
      prog.push_back(enc_i(8, 0, 3, 2, 7'h03));      //  4 ld  x2,8(x0)
      prog.push_back(enc_r(0, 2, 1, 0, 3));          //  8 add x3,x1,x2
      prog.push_back(enc_s(16, 3, 0, 3));            // 12 sd  x3,16(x0)
      prog.push_back(enc_r(32, 2, 1, 0, 4));         // 16 sub x4,x1,x2
      prog.push_back(enc_b(8, 1, 1, 0));             // 20 beq x1,x1,+8
      prog.push_back(enc_i(99, 0, 0, 9, 7'h13));     // 24 addi x9 (skipped)
      prog.push_back(enc_b(8, 2, 1, 0));             // 28 beq x1,x2,+8
      prog.push_back(enc_r(0, 2, 1, 7, 5));          // 32 and x5
      prog.push_back(enc_r(0, 2, 1, 6, 6));          // 36 or  x6
      prog.push_back(enc_i(-1, 0, 0, 7, 7'h13));     // 40 addi x7,x0,-1
      prog.push_back(enc_i(5, 0, 0, 0, 7'h13));      // 44 addi x0,x0,5
      prog.push_back(32'h0000007F);                  // 48 unknown opcode
      prog.push_back(enc_b(-4, 0, 0, 0));            // 52 beq x0,x0,-4
      load_prog(prog);
      do_reset(2, "reset0");

      run(4);
      chk("dir_pc_after4", dut.pc_reg.OUT, 64'd16);
      chk("dir_x1", dut.regfile.registers[1], 64'd10);
      chk("dir_x2", dut.regfile.registers[2], 64'd20);
      chk("dir_x3", dut.regfile.registers[3], 64'd30);
      for (int k = 0; k < 8; k++) v[8*k +: 8] = dut.dmem.memory[16 + k];
      chk("dir_dmem16", v, 64'd30);
      run(2);
      chk("dir_beq_taken_pc", dut.pc_reg.OUT, 64'd28);
      run(1);
      chk("dir_beq_not_taken_pc", dut.pc_reg.OUT, 64'd32);
      run(7);
      chk("dir_x4_sub", dut.regfile.registers[4], 64'hFFFF_FFFF_FFFF_FFF6);
      chk("dir_x5_and", dut.regfile.registers[5], 64'd0);
      chk("dir_x6_or",  dut.regfile.registers[6], 64'd30);
      chk("dir_x7_addi", dut.regfile.registers[7], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("dir_x9_skipped", dut.regfile.registers[9], 64'd0);
      chk("dir_x0", dut.regfile.registers[0], 64'd0);
      chk("dir_loop_pc", dut.pc_reg.OUT, 64'd52);
      do_reset(1, "dir_midreset");
      chk("dir_dmem16_kept", {dut.dmem.memory[23], dut.dmem.memory[22], dut.dmem.memory[21],
                              dut.dmem.memory[20], dut.dmem.memory[19], dut.dmem.memory[18],
                              dut.dmem.memory[17], dut.dmem.memory[16]}, 64'd30);

      // ---- randomized programs ----
      for (int r = 0; r < 4; r++) begin
         rst = 1'b1;
         set_dmem_random();
         prog = {};
         for (int i = 0; i < IMEM_WORDS; i++) prog.push_back(rand_instr());
         load_prog(prog);
         do_reset(2, $sformatf("rnd%0d_reset", r));
         run(3);
         do_reset(1, $sformatf("rnd%0d_midreset", r));
         run(60);
      end

      @(negedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
